// File: rtl/mpu_guard_pkg.sv
// Shared types and helpers for the per-context MPU guard: the region config word layout
// and the load/store opcode encoding.
package mpu_guard_pkg;

    localparam int MPU_ADDR_W = 16;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    function automatic int cfg_w(input int addr_w);
        return 2 * addr_w;
    endfunction

    localparam int CFG_W = cfg_w(MPU_ADDR_W);

    // Base is word aligned, so its two low bits are implicit zeros.
    typedef struct packed {
        logic [MPU_ADDR_W-3:0] base;
        logic [MPU_ADDR_W-1:0] len;
        logic                  wr_en;
        logic                  rd_en;
    } region_t;

    function automatic region_t cfg_unpack(input logic [CFG_W-1:0] w);
        return region_t'(w);
    endfunction

    function automatic logic [CFG_W-1:0] cfg_pack(input region_t r);
        return CFG_W'(r);
    endfunction

endpackage

// File: rtl/mpu_ep_stack.sv
// Entry-pointer stack: the SP is pushed on interrupt entry and popped on return.
// EP is the top entry, or 0 when the stack is empty.
module mpu_ep_stack #(
    parameter int ADDR_W     = 16,
    parameter int NEST_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enter_i,
    input  logic              exit_i,
    input  logic [ADDR_W-1:0] sp_i,
    output logic [ADDR_W-1:0] ep_o,
    output logic              ovf_o,
    output logic              unf_o
);

    localparam int DW = $clog2(NEST_DEPTH + 1);
    localparam int IW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    logic [DW-1:0]     depth_q, depth_d;
    logic [ADDR_W-1:0] stk_q [NEST_DEPTH];
    logic              empty, full, push, pop, repl;
    logic [IW-1:0]     top_idx, wr_idx;

    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DW'(NEST_DEPTH));
    assign top_idx = IW'(depth_q - DW'(1));

    // Enter together with exit replaces the top, except on an empty stack where it pushes.
    assign repl  = enter_i && exit_i && !empty;
    assign push  = enter_i && (!exit_i || empty) && !full;
    assign pop   = exit_i && !enter_i && !empty;
    assign ovf_o = enter_i && !exit_i && full;
    assign unf_o = exit_i && !enter_i && empty;

    assign wr_idx = repl ? top_idx : IW'(depth_q);
    assign ep_o   = empty ? '0 : stk_q[top_idx];

    always_comb begin
        depth_d = depth_q;
        if (push)
            depth_d = depth_q + DW'(1);
        else if (pop)
            depth_d = depth_q - DW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            depth_q <= '0;
        else
            depth_q <= depth_d;
    end

    always_ff @(posedge clk) begin
        if (push || repl)
            stk_q[wr_idx] <= sp_i;
    end

endmodule

// File: rtl/mpu_ctx_guard.sv
// Per-context memory protection unit: own-stack-frame check against the nested EP plus
// programmable region windows. Optional macro MPU_GUARD_FAULT_CNT_EN adds fault_cnt.
module mpu_ctx_guard
    import mpu_guard_pkg::*;
#(
    parameter int ADDR_W     = MPU_ADDR_W,
    parameter int CTX        = 9,
    parameter int REGIONS    = 4,
    parameter int NEST_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       acc_valid,
    input  logic                       acc_store,
    input  logic [ADDR_W-1:0]          acc_addr,
    input  logic [ADDR_W-1:0]          sp,
    input  logic [$clog2(CTX)-1:0]     ctx_id,
    input  logic                       ctx_enter,
    input  logic                       ctx_exit,
    input  logic                       cfg_we,
    input  logic [$clog2(CTX)-1:0]     cfg_ctx,
    input  logic [$clog2(REGIONS)-1:0] cfg_idx,
    input  logic [2*ADDR_W-1:0]        cfg_wdata,
    input  logic                       fault_clr,
    output logic                       fault_o,
    output logic                       fault_pending,
    output logic [ADDR_W-1:0]          fault_addr,
    output logic [$clog2(CTX)-1:0]     fault_ctx,
    output logic                       fault_store,
`ifdef MPU_GUARD_FAULT_CNT_EN
    output logic [7:0]                 fault_cnt,
`endif
    output logic                       nest_err
);

    localparam int CTX_W = $clog2(CTX);
    localparam int EW    = ADDR_W + 1;

    logic [ADDR_W-1:0] ep;
    logic              ovf, unf;

    mpu_ep_stack #(
        .ADDR_W     (ADDR_W),
        .NEST_DEPTH (NEST_DEPTH)
    ) u_ep_stack (
        .clk     (clk),
        .reset   (reset),
        .enter_i (ctx_enter),
        .exit_i  (ctx_exit),
        .sp_i    (sp),
        .ep_o    (ep),
        .ovf_o   (ovf),
        .unf_o   (unf)
    );

    region_t tbl_q [CTX][REGIONS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CTX; c++)
                for (int r = 0; r < REGIONS; r++)
                    tbl_q[c][r] <= '0;
        end else if (cfg_we && (int'(cfg_ctx) < CTX)) begin
            tbl_q[cfg_ctx][cfg_idx] <= cfg_unpack(cfg_wdata);
        end
    end

    // Window bounds use one extra bit so a region ending past the top of memory never wraps.
    logic                ctx_ok;
    logic [REGIONS-1:0]  grant;
    logic                allowed, viol;

    assign ctx_ok = (int'(ctx_id) < CTX);

    for (genvar k = 0; k < REGIONS; k++) begin : g_region
        region_t        r;
        logic [EW-1:0]  bot, top, a;
        logic           hit, perm;

        assign r    = ctx_ok ? tbl_q[ctx_id][k] : '0;
        assign bot  = {1'b0, r.base, 2'b00};
        assign top  = bot + EW'(r.len);
        assign a    = {1'b0, acc_addr};
        assign hit  = (a >= bot) && (a <= top);
        assign perm = (acc_store == OP_LOAD) ? r.rd_en : r.wr_en;
        assign grant[k] = hit && perm;
    end

    assign allowed = (acc_addr < ep) || (|grant);
    assign viol    = acc_valid && !allowed;

    logic               fault_q, pend_q, pend_d, st_q, st_d, nerr_q, nerr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CTX_W-1:0]   fctx_q, fctx_d;

    always_comb begin
        pend_d = pend_q;
        addr_d = addr_q;
        fctx_d = fctx_q;
        st_d   = st_q;
        nerr_d = nerr_q;
        if (viol && (!pend_q || fault_clr)) begin
            pend_d = 1'b1;
            addr_d = acc_addr;
            fctx_d = ctx_id;
            st_d   = acc_store;
        end else if (fault_clr) begin
            pend_d = 1'b0;
        end
        if (ovf || unf)
            nerr_d = 1'b1;
        else if (fault_clr)
            nerr_d = 1'b0;
    end

    // Check stage: results appear one cycle after the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            fctx_q  <= '0;
            st_q    <= 1'b0;
            nerr_q  <= 1'b0;
        end else begin
            fault_q <= viol;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            fctx_q  <= fctx_d;
            st_q    <= st_d;
            nerr_q  <= nerr_d;
        end
    end

    assign fault_o       = fault_q;
    assign fault_pending = pend_q;
    assign fault_addr    = addr_q;
    assign fault_ctx     = fctx_q;
    assign fault_store   = st_q;
    assign nest_err      = nerr_q;

`ifdef MPU_GUARD_FAULT_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fault_clr)
            cnt_d = viol ? 8'd1 : 8'd0;
        else if (viol && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign fault_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mpu_ctx_guard.sv
// Scoreboard bench for mpu_ctx_guard: stimulus queues expected check results, a monitor
// compares them when each check result is due. Counter checks need MPU_GUARD_FAULT_CNT_EN.
module tb_mpu_ctx_guard;
    import mpu_guard_pkg::*;

    localparam int AW = 16;
    localparam int CW = 4;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          acc_valid, acc_store;
    logic [AW-1:0] acc_addr, sp;
    logic [CW-1:0] ctx_id, cfg_ctx;
    logic          ctx_enter, ctx_exit, cfg_we, fault_clr;
    logic [RW-1:0] cfg_idx;
    logic [2*AW-1:0] cfg_wdata;
    logic          fault_o, fault_pending, fault_store, nest_err;
    logic [AW-1:0] fault_addr;
    logic [CW-1:0] fault_ctx;
`ifdef MPU_GUARD_FAULT_CNT_EN
    logic [7:0]    fault_cnt;
`endif

    always #5 clk = ~clk;

    mpu_ctx_guard dut (
        .clk           (clk),
        .reset         (reset),
        .acc_valid     (acc_valid),
        .acc_store     (acc_store),
        .acc_addr      (acc_addr),
        .sp            (sp),
        .ctx_id        (ctx_id),
        .ctx_enter     (ctx_enter),
        .ctx_exit      (ctx_exit),
        .cfg_we        (cfg_we),
        .cfg_ctx       (cfg_ctx),
        .cfg_idx       (cfg_idx),
        .cfg_wdata     (cfg_wdata),
        .fault_clr     (fault_clr),
        .fault_o       (fault_o),
        .fault_pending (fault_pending),
        .fault_addr    (fault_addr),
        .fault_ctx     (fault_ctx),
        .fault_store   (fault_store),
`ifdef MPU_GUARD_FAULT_CNT_EN
        .fault_cnt     (fault_cnt),
`endif
        .nest_err      (nest_err)
    );

    typedef struct packed {
        logic          f;
        logic          pend;
        logic [AW-1:0] addr;
        logic [CW-1:0] ctx;
        logic          st;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad   = 0;
    logic          chk_due = 1'b0;
    logic          exp_pend = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [CW-1:0] exp_ctx  = '0;
    logic          exp_st   = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(posedge clk) chk_due <= acc_valid && !reset;

    always @(negedge clk) begin
        if (chk_due) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: check result with no expectation queued");
            end else begin
                mon_e = q.pop_front();
                cmp("fault_o", fault_o, mon_e.f);
                cmp("fault_pending", fault_pending, mon_e.pend);
                if (mon_e.pend) begin
                    cmp("fault_addr", fault_addr, mon_e.addr);
                    cmp("fault_ctx", fault_ctx, mon_e.ctx);
                    cmp("fault_store", fault_store, mon_e.st);
                end
            end
        end else if (!reset) begin
            cmp("idle_fault_o", fault_o, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic st, input logic [AW-1:0] a, input logic [CW-1:0] c,
                          input logic f, input logic clr);
        exp_t e;
        acc_valid = 1'b1;
        acc_store = st;
        acc_addr  = a;
        ctx_id    = c;
        fault_clr = clr;
        if (f && (!exp_pend || clr)) begin
            exp_pend = 1'b1;
            exp_addr = a;
            exp_ctx  = c;
            exp_st   = st;
        end else if (clr) begin
            exp_pend = 1'b0;
        end
        e.f = f; e.pend = exp_pend; e.addr = exp_addr; e.ctx = exp_ctx; e.st = exp_st;
        q.push_back(e);
        tick();
        acc_valid = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic clr();
        fault_clr = 1'b1;
        exp_pend  = 1'b0;
        tick();
        fault_clr = 1'b0;
    endtask

    task automatic stack_op(input logic en, input logic ex, input logic [AW-1:0] s);
        ctx_enter = en;
        ctx_exit  = ex;
        sp        = s;
        tick();
        ctx_enter = 1'b0;
        ctx_exit  = 1'b0;
    endtask

    task automatic set_cfg(input logic [CW-1:0] c, input logic [RW-1:0] idx, input logic [AW-1:0] bot,
                           input logic [AW-1:0] len, input logic wr, input logic rd);
        region_t r;
        r.base = bot[AW-1:2];
        r.len = len;
        r.wr_en = wr;
        r.rd_en = rd;
        cfg_ctx = c;
        cfg_idx = idx;
        cfg_wdata = cfg_pack(r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; acc_valid = 1'b0; acc_store = 1'b0; acc_addr = '0; sp = '0;
        ctx_id = '0; ctx_enter = 1'b0; ctx_exit = 1'b0; cfg_we = 1'b0; cfg_ctx = '0;
        cfg_idx = '0; cfg_wdata = '0; fault_clr = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        cmp("rst_fault_o", fault_o, 1'b0);
        cmp("rst_pending", fault_pending, 1'b0);
        cmp("rst_addr", fault_addr, 16'h0);
        cmp("rst_nest_err", nest_err, 1'b0);
        access(OP_LOAD, 16'h0000, 4'd0, 1'b1, 1'b0);   // EP = 0 grants nothing
        clr();

        // Own stack frame
        stack_op(1'b1, 1'b0, 16'h0800);
        access(OP_LOAD, 16'h07F0, 4'd0, 1'b0, 1'b0);
        access(OP_LOAD, 16'h0900, 4'd0, 1'b1, 1'b0);
        clr();

        // Region window on ctx 2
        cfg_we = 1'b1;
        set_cfg(4'd2, 2'd0, 16'h1000, 16'h00FF, 1'b0, 1'b1);
        tick();
        cfg_we = 1'b0;
        access(OP_LOAD,  16'h10FF, 4'd2, 1'b0, 1'b0);
        access(OP_LOAD,  16'h1100, 4'd2, 1'b1, 1'b0);
        clr();
        access(OP_STORE, 16'h1010, 4'd2, 1'b1, 1'b0);
        access(OP_LOAD,  16'h1000, 4'd2, 1'b0, 1'b0);
        access(OP_LOAD,  16'h0FFF, 4'd2, 1'b1, 1'b0);
        access(OP_LOAD,  16'h1010, 4'd1, 1'b1, 1'b0);
        clr();

        // Nesting
        stack_op(1'b0, 1'b1, 16'h0000);
        stack_op(1'b1, 1'b0, 16'h0800);
        stack_op(1'b1, 1'b0, 16'h0600);
        stack_op(1'b0, 1'b1, 16'h0000);
        access(OP_LOAD, 16'h0700, 4'd0, 1'b0, 1'b0);
        stack_op(1'b0, 1'b1, 16'h0000);
        access(OP_LOAD, 16'h0700, 4'd0, 1'b1, 1'b0);
        access(OP_LOAD, 16'h0000, 4'd0, 1'b1, 1'b0);
        stack_op(1'b1, 1'b1, 16'h0400);
        access(OP_LOAD, 16'h03FF, 4'd0, 1'b0, 1'b0);
        access(OP_LOAD, 16'h0400, 4'd0, 1'b1, 1'b0);
        stack_op(1'b1, 1'b1, 16'h0200);
        access(OP_LOAD, 16'h0300, 4'd0, 1'b1, 1'b0);
        access(OP_LOAD, 16'h01FF, 4'd0, 1'b0, 1'b0);
        stack_op(1'b0, 1'b1, 16'h0000);
        cmp("nest_err_balanced", nest_err, 1'b0);
        clr();

        // Overflow and underflow
        for (int i = 0; i < 9; i++) stack_op(1'b1, 1'b0, 16'((i + 1) * 16'h0100));
        cmp("nest_err_ovf", nest_err, 1'b1);
        access(OP_LOAD, 16'h07FF, 4'd0, 1'b0, 1'b0);
        access(OP_LOAD, 16'h0800, 4'd0, 1'b1, 1'b0);
        clr();
        cmp("nest_err_clr", nest_err, 1'b0);
        for (int i = 0; i < 8; i++) stack_op(1'b0, 1'b1, 16'h0000);
        cmp("nest_err_empty", nest_err, 1'b0);
        stack_op(1'b0, 1'b1, 16'h0000);
        cmp("nest_err_unf", nest_err, 1'b1);
        clr();

        // Fault record capture
        access(OP_LOAD, 16'h0900, 4'd0, 1'b1, 1'b0);
        access(OP_LOAD, 16'h0A00, 4'd0, 1'b1, 1'b0);
        access(OP_LOAD, 16'h0B00, 4'd0, 1'b1, 1'b1);
        clr();

        // Table write versus same-cycle check, inclusive top, no address wrap
        cfg_we = 1'b1;
        set_cfg(4'd0, 2'd1, 16'h2000, 16'h0010, 1'b0, 1'b1);
        access(OP_LOAD, 16'h2004, 4'd0, 1'b1, 1'b0);
        cfg_we = 1'b0;
        access(OP_LOAD, 16'h2004, 4'd0, 1'b0, 1'b0);
        access(OP_LOAD, 16'h2010, 4'd0, 1'b0, 1'b0);
        access(OP_LOAD, 16'h2011, 4'd0, 1'b1, 1'b0);
        clr();
        cfg_we = 1'b1;
        set_cfg(4'd3, 2'd3, 16'hFFFC, 16'h0010, 1'b1, 1'b0);
        tick();
        cfg_we = 1'b0;
        access(OP_STORE, 16'hFFFE, 4'd3, 1'b0, 1'b0);
        access(OP_LOAD,  16'hFFFE, 4'd3, 1'b1, 1'b0);
        access(OP_STORE, 16'h0004, 4'd3, 1'b1, 1'b0);
        clr();

`ifdef MPU_GUARD_FAULT_CNT_EN
        cmp("cnt_clr", fault_cnt, 8'd0);
        for (int i = 0; i < 3; i++) access(OP_LOAD, 16'h0900, 4'd0, 1'b1, 1'b0);
        cmp("cnt_3", fault_cnt, 8'd3);
        for (int i = 0; i < 254; i++) access(OP_LOAD, 16'h0900, 4'd0, 1'b1, 1'b0);
        cmp("cnt_sat", fault_cnt, 8'd255);
        access(OP_LOAD, 16'h0900, 4'd0, 1'b1, 1'b1);
        cmp("cnt_clr_fault", fault_cnt, 8'd1);
        clr();
        cmp("cnt_cleared", fault_cnt, 8'd0);
`endif

        // Reset while a check is outstanding discards it and clears the table
        acc_valid = 1'b1; acc_store = OP_LOAD; acc_addr = 16'h0900; ctx_id = 4'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acc_valid = 1'b0;
        exp_pend = 1'b0;
        cmp("rst_drop_fault_o", fault_o, 1'b0);
        cmp("rst_drop_pending", fault_pending, 1'b0);
        tick();
        cmp("rst_drop_next", fault_o, 1'b0);
        access(OP_LOAD, 16'h2004, 4'd0, 1'b1, 1'b0);

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
